// File: rtl/smu_dcu_resp.sv
// smu_dcu_resp: data-cache-side responder for stack-manager spill/fill traffic.
// Spills are posted into a small in-order write buffer that drains to the
// memory port. Fills are served from the youngest matching buffer entry.
// On a buffer miss, the buffer is drained first and the word is then read
// from memory, so a fill can never overtake an older spill to the same word.
module smu_dcu_resp #(
  parameter int WB_DEPTH = 4,
  parameter int WB_PW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        smu_ld,
  input  logic        smu_st,
  input  logic [31:0] smu_addr,
  input  logic [31:0] smu_data,
  output logic        smu_stall,
  output logic [31:0] dcu_data,
  output logic        dcu_data_vld,
  output logic        wb_empty,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_LD_DRAIN = 2'd1,
    ST_LD_MEM   = 2'd2
  } state_e;

  // Registered state
  state_e             state_q, state_d;
  logic [WB_PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [WB_PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [WB_PW:0]     count_q, count_d;
  logic [29:0]        ld_addr_q, ld_addr_d;
  logic [31:0]        dcu_data_q, dcu_data_d;
  logic               dcu_vld_q, dcu_vld_d;
  logic [29:0]        wb_addr_q [WB_DEPTH];
  logic [31:0]        wb_data_q [WB_DEPTH];

  // Combinational helpers
  logic               accept_s;
  logic               st_acc_s;
  logic               ld_acc_s;
  logic               drain_s;
  logic               drain_done_s;
  logic               hit_s;
  logic [31:0]        hit_data_s;
  logic               unused_s;

  // Byte-offset bits of the request address carry no meaning for word traffic.
  assign unused_s = ^smu_addr[1:0];

  // Request handshake: stall while the buffer is full or a fill is in flight.
  assign smu_stall    = (count_q == WB_DEPTH[WB_PW:0]) | (state_q != ST_IDLE);
  assign accept_s     = (smu_ld | smu_st) & ~smu_stall;
  // A simultaneous load and store keeps the store and silently drops the load.
  assign st_acc_s     = accept_s & smu_st;
  assign ld_acc_s     = accept_s & smu_ld & ~smu_st;

  // The buffer drains whenever it has entries and no memory read owns the port.
  assign drain_s      = (count_q != '0) & ((state_q == ST_IDLE) | (state_q == ST_LD_DRAIN));
  assign drain_done_s = drain_s & mem_ack;

  // Memory port is a pure function of registers so it only changes on a clock
  // edge (stable while waiting for ack) and drops at once on reset.
  assign mem_req      = drain_s | (state_q == ST_LD_MEM);
  assign mem_we       = drain_s;
  assign mem_addr     = (state_q == ST_LD_MEM) ? {ld_addr_q, 2'b00} : {wb_addr_q[rd_ptr_q], 2'b00};
  assign mem_wdata    = wb_data_q[rd_ptr_q];

  assign wb_empty     = (count_q == '0);
  assign dcu_data     = dcu_data_q;
  assign dcu_data_vld = dcu_vld_q;

  // Buffer lookup: scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    logic [WB_PW-1:0] idx_v;
    hit_s      = 1'b0;
    hit_data_s = 32'h0000_0000;
    idx_v      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx_v = rd_ptr_q + WB_PW'(i);
      if (((WB_PW+1)'(i) < count_q) && (wb_addr_q[idx_v] == smu_addr[31:2])) begin
        hit_s      = 1'b1;
        hit_data_s = wb_data_q[idx_v];
      end else begin
        hit_s      = hit_s;
        hit_data_s = hit_data_s;
      end
    end
  end

  // Next-state logic for pointers, occupancy, fill FSM and fill response.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ld_addr_d  = ld_addr_q;
    dcu_data_d = dcu_data_q;
    dcu_vld_d  = 1'b0;

    if (st_acc_s) begin
      wr_ptr_d = wr_ptr_q + {{(WB_PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (drain_done_s) begin
      rd_ptr_d = rd_ptr_q + {{(WB_PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Accept and drain in the same cycle cancel out.
    count_d = count_q + {{WB_PW{1'b0}}, st_acc_s} - {{WB_PW{1'b0}}, drain_done_s};

    case (state_q)
      ST_IDLE: begin
        if (ld_acc_s) begin
          if (hit_s) begin
            dcu_data_d = hit_data_s;
            dcu_vld_d  = 1'b1;
          end else if (count_q != '0) begin
            ld_addr_d = smu_addr[31:2];
            state_d   = ST_LD_DRAIN;
          end else begin
            ld_addr_d = smu_addr[31:2];
            state_d   = ST_LD_MEM;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LD_DRAIN: begin
        // Move on as soon as the last buffered spill is acknowledged.
        if ((count_q == '0) || ((count_q == {{WB_PW{1'b0}}, 1'b1}) && mem_ack)) begin
          state_d = ST_LD_MEM;
        end else begin
          state_d = ST_LD_DRAIN;
        end
      end
      ST_LD_MEM: begin
        if (mem_ack) begin
          dcu_data_d = mem_rdata;
          dcu_vld_d  = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_LD_MEM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ld_addr_q  <= 30'h0000_0000;
      dcu_data_q <= 32'h0000_0000;
      dcu_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ld_addr_q  <= ld_addr_d;
      dcu_data_q <= dcu_data_d;
      dcu_vld_q  <= dcu_vld_d;
    end
  end

  // Write-buffer storage: accepted spills land at the write pointer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_addr_q[i] <= 30'h0000_0000;
        wb_data_q[i] <= 32'h0000_0000;
      end
    end else if (st_acc_s) begin
      wb_addr_q[wr_ptr_q] <= smu_addr[31:2];
      wb_data_q[wr_ptr_q] <= smu_data;
    end
  end

endmodule
